// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Request, ALU-side and result-side signals of alu_arbiter, bundled as one port.
// slave  : the arbiter's view (offers in, grants out, ALU inputs out, results out).
// master : the view of the surrounding issue lanes, ALU and writeback consumer.
interface alu_arbiter_if;
  // issue lanes
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_op0;
  logic [11:0] req_op1;
  logic [15:0] req_a0;
  logic [15:0] req_b0;
  logic [15:0] req_a1;
  logic [15:0] req_b1;
  logic [4:0]  req_imm0;
  logic [4:0]  req_imm1;
  logic [1:0]  req_isimm;
  // shared ALU
  logic [11:0] alu_signals;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [4:0]  alu_immx;
  logic        alu_isimm;
  logic [15:0] alu_result;
  // result stream
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_lane;
  logic        op_err;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_imm0, req_imm1, req_isimm, alu_result, res_ready,
    output req_ready, alu_signals, alu_op1, alu_op2, alu_immx, alu_isimm,
           res_valid, res_data, res_lane, op_err
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           req_imm0, req_imm1, req_isimm, alu_result, res_ready,
    input  req_ready, alu_signals, alu_op1, alu_op2, alu_immx, alu_isimm,
           res_valid, res_data, res_lane, op_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one fixed-latency ALU between two issue lanes. At most one one-hot op
// is granted per cycle, its fields are registered onto the ALU inputs, a tag
// follows it through the ALU latency, and the result is queued with its lane in
// a small FIFO. Issue is credit-limited so every issued op owns a FIFO slot by
// the time its result appears, which lets the ALU run without back-pressure.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to give lane 0 priority whenever
// both lanes are eligible (no round-robin pointer is built). Default build is
// round-robin.
module alu_arbiter #(
  parameter int LAT   = 2,   // ALU cycles from input presentation to result
  parameter int DEPTH = 4    // result FIFO entries, must be >= LAT
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  // Wide enough for inflight + fifo_count and for DEPTH itself.
  localparam int CW = $clog2(DEPTH + LAT + 2);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic is_onehot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

  function automatic logic [CW-1:0] count_ones(input logic [LAT:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i <= LAT; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Circular pointer step; also correct for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Per-lane views of the request fields
  // ---------------------------------------------------------------------------
  logic [1:0][11:0] op_s;
  logic [1:0][15:0] a_s;
  logic [1:0][15:0] b_s;
  logic [1:0][4:0]  imm_s;

  assign op_s  = {bus.req_op1,  bus.req_op0};
  assign a_s   = {bus.req_a1,   bus.req_a0};
  assign b_s   = {bus.req_b1,   bus.req_b0};
  assign imm_s = {bus.req_imm1, bus.req_imm0};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [11:0]      alu_signals_q;
  logic [15:0]      alu_op1_q;
  logic [15:0]      alu_op2_q;
  logic [4:0]       alu_immx_q;
  logic             alu_isimm_q;

  // Stage 0 lines up with the cycle the op sits on the ALU inputs; stage LAT
  // lines up with the cycle its result is on alu_result.
  logic [LAT:0]     trk_vld_q;
  logic [LAT:0]     trk_lane_q;

  logic [15:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0] fifo_lane_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;

  logic [1:0]       bad_seen_q;
  logic [1:0][11:0] bad_op_q;
  logic             op_err_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_q;
`endif

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]    valid_s;
  logic [1:0]    bad_s;
  logic [1:0]    new_err_s;
  logic [CW-1:0] inflight_s;
  logic          credit_s;
  logic [1:0]    elig_s;
  logic          gnt_s;
  logic          win_s;
  logic [1:0]    ready_s;
  logic          res_valid_s;
  logic          push_s;
  logic          pop_s;

  // Split each lane's offer into well-formed and malformed; a malformed op only
  // reports an error on the first cycle it is seen unchanged.
  always_comb begin
    valid_s   = 2'b00;
    bad_s     = 2'b00;
    new_err_s = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (bus.req_valid[n]) begin
        if (is_onehot(op_s[n])) begin
          valid_s[n] = 1'b1;
        end else begin
          bad_s[n]     = 1'b1;
          new_err_s[n] = !(bad_seen_q[n] && (bad_op_q[n] == op_s[n]));
        end
      end else begin
        valid_s[n] = 1'b0;
      end
    end
  end

  // Credit uses registered occupancy only, so a pop frees a slot next cycle.
  assign inflight_s = count_ones(trk_vld_q);
  assign credit_s   = (inflight_s + fifo_cnt_q) < CW'(DEPTH);
  assign elig_s     = (rst || !credit_s) ? 2'b00 : valid_s;

  // Pick the winning lane among the eligible ones.
  always_comb begin
    gnt_s = 1'b0;
    win_s = 1'b0;
    case (elig_s)
      2'b01: begin
        gnt_s = 1'b1;
        win_s = 1'b0;
      end
      2'b10: begin
        gnt_s = 1'b1;
        win_s = 1'b1;
      end
      2'b11: begin
        gnt_s = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_s = 1'b0;
`else
        win_s = ~last_q;
`endif
      end
      default: begin
        gnt_s = 1'b0;
        win_s = 1'b0;
      end
    endcase
  end

  assign ready_s     = gnt_s ? (win_s ? 2'b10 : 2'b01) : 2'b00;
  assign res_valid_s = (fifo_cnt_q != '0);
  assign pop_s       = res_valid_s && bus.res_ready;
  assign push_s      = trk_vld_q[LAT];

  // FIFO pointer and occupancy next state; simultaneous push and pop holds the count.
  always_comb begin
    wr_ptr_d   = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer: remembers the last granted lane; starts at 1 so lane 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (gnt_s) begin
      last_q <= win_s;
    end else begin
      last_q <= last_q;
    end
  end
`endif

  // Register the winner's fields onto the ALU inputs; idle cycles present a zero op.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_signals_q <= 12'd0;
      alu_op1_q     <= 16'd0;
      alu_op2_q     <= 16'd0;
      alu_immx_q    <= 5'd0;
      alu_isimm_q   <= 1'b0;
    end else if (gnt_s) begin
      alu_signals_q <= op_s[win_s];
      alu_op1_q     <= a_s[win_s];
      alu_op2_q     <= b_s[win_s];
      alu_immx_q    <= imm_s[win_s];
      alu_isimm_q   <= bus.req_isimm[win_s];
    end else begin
      alu_signals_q <= 12'd0;
      alu_op1_q     <= 16'd0;
      alu_op2_q     <= 16'd0;
      alu_immx_q    <= 5'd0;
      alu_isimm_q   <= 1'b0;
    end
  end

  // Carry a valid/lane tag alongside each op through the ALU latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q  <= '0;
      trk_lane_q <= '0;
    end else begin
      trk_vld_q  <= {trk_vld_q[LAT-1:0],  gnt_s};
      trk_lane_q <= {trk_lane_q[LAT-1:0], win_s};
    end
  end

  // Result FIFO storage and pointers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= 16'd0;
      end
      fifo_lane_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= bus.alu_result;
        fifo_lane_q[wr_ptr_q] <= trk_lane_q[LAT];
      end else begin
        fifo_lane_q <= fifo_lane_q;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Track malformed offers per lane and pulse op_err once per new malformed op.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_seen_q <= 2'b00;
      bad_op_q   <= '0;
      op_err_q   <= 1'b0;
    end else begin
      bad_seen_q <= bad_s;
      bad_op_q   <= op_s;
      op_err_q   <= |new_err_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready   = ready_s;
  assign bus.alu_signals = alu_signals_q;
  assign bus.alu_op1     = alu_op1_q;
  assign bus.alu_op2     = alu_op2_q;
  assign bus.alu_immx    = alu_immx_q;
  assign bus.alu_isimm   = alu_isimm_q;
  assign bus.res_valid   = res_valid_s;
  assign bus.res_data    = fifo_data_q[rd_ptr_q];
  assign bus.res_lane    = fifo_lane_q[rd_ptr_q];
  assign bus.op_err      = op_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter (LAT=2, DEPTH=4) with a small pipelined ALU
// model behind it. Honours ALU_ARB_FIXED_PRIO_EN for the arbitration patterns.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if bus();

  alu_arbiter #(.LAT(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: add, sub, and, or on one-hot select; operand 2 may be the immediate.
  function automatic logic [15:0] alu_f(input logic [11:0] s, input logic [15:0] a,
                                        input logic [15:0] b, input logic [4:0] imm,
                                        input logic im);
    logic [15:0] o2;
    o2 = im ? {11'd0, imm} : b;
    case (s)
      12'h001: return a + o2;
      12'h002: return a - o2;
      12'h004: return a & o2;
      12'h008: return a | o2;
      default: return 16'd0;
    endcase
  endfunction

  logic [15:0] alu_p0, alu_p1;
  always @(posedge clk) begin
    alu_p0 <= alu_f(bus.alu_signals, bus.alu_op1, bus.alu_op2, bus.alu_immx, bus.alu_isimm);
    alu_p1 <= alu_p0;
  end
  assign bus.alu_result = alu_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = 2'b00;
    bus.req_op0 = 12'd0;  bus.req_op1 = 12'd0;
    bus.req_a0 = 16'd0;   bus.req_b0 = 16'd0;
    bus.req_a1 = 16'd0;   bus.req_b1 = 16'd0;
    bus.req_imm0 = 5'd0;  bus.req_imm1 = 5'd0;
    bus.req_isimm = 2'b00;
    bus.res_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_op0 = 12'h001; bus.req_op1 = 12'h002;
    tick();
    tick();
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.alu_signals !== 12'd0) begin errors++; $display("FAIL rst_alu_signals: got %h expected 000", bus.alu_signals); end
    checks++; if (bus.alu_op1 !== 16'd0 || bus.alu_op2 !== 16'd0) begin errors++; $display("FAIL rst_alu_ops: got %h/%h expected 0/0", bus.alu_op1, bus.alu_op2); end
    checks++; if (bus.alu_immx !== 5'd0 || bus.alu_isimm !== 1'b0) begin errors++; $display("FAIL rst_alu_imm: got %h/%b expected 0/0", bus.alu_immx, bus.alu_isimm); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", bus.res_valid); end
    checks++; if (bus.res_data !== 16'd0 || bus.res_lane !== 1'b0) begin errors++; $display("FAIL rst_res_data: got %h lane %b expected 0 lane 0", bus.res_data, bus.res_lane); end
    checks++; if (bus.op_err !== 1'b0) begin errors++; $display("FAIL rst_op_err: got %b expected 0", bus.op_err); end
  endtask

  task automatic test_reset_start();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd3; bus.req_b0 = 16'd4;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL start_grant: got %b expected 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.alu_signals !== 12'h001 || bus.alu_op1 !== 16'd3 || bus.alu_op2 !== 16'd4) begin
      errors++; $display("FAIL start_alu_inputs: got %h %0d %0d expected 001 3 4", bus.alu_signals, bus.alu_op1, bus.alu_op2);
    end
    for (int c = 1; c < 4; c++) begin
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL start_early_valid: cycle %0d got %b expected 0", c, bus.res_valid); end
      tick();
      #1;
    end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL start_res_valid: got %b expected 1", bus.res_valid); end
    checks++; if (bus.res_data !== 16'd7 || bus.res_lane !== 1'b0) begin errors++; $display("FAIL start_res_data: got %0d lane %b expected 7 lane 0", bus.res_data, bus.res_lane); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL start_pop: got %b expected 0", bus.res_valid); end
  endtask

  task automatic test_immediate();
    int cyc;
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_op1 = 12'h002; bus.req_a1 = 16'd50; bus.req_b1 = 16'd999;
    bus.req_imm1 = 5'd7; bus.req_isimm = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL imm_grant: got %b expected 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    #1;
    checks++; if (bus.alu_signals !== 12'h002 || bus.alu_op1 !== 16'd50 || bus.alu_op2 !== 16'd999) begin
      errors++; $display("FAIL imm_alu_ops: got %h %0d %0d expected 002 50 999", bus.alu_signals, bus.alu_op1, bus.alu_op2);
    end
    checks++; if (bus.alu_immx !== 5'd7 || bus.alu_isimm !== 1'b1) begin errors++; $display("FAIL imm_alu_imm: got %0d/%b expected 7/1", bus.alu_immx, bus.alu_isimm); end
    tick();
    #1;
    checks++; if (bus.alu_signals !== 12'd0) begin errors++; $display("FAIL imm_idle_signals: got %h expected 000", bus.alu_signals); end
    cyc = 2;
    while (bus.res_valid !== 1'b1 && cyc < 10) begin
      tick();
      #1;
      cyc++;
    end
    checks++; if (cyc != 4) begin errors++; $display("FAIL imm_latency: result at cycle %0d expected 4", cyc); end
    checks++; if (bus.res_data !== 16'd43 || bus.res_lane !== 1'b1) begin errors++; $display("FAIL imm_result: got %0d lane %b expected 43 lane 1", bus.res_data, bus.res_lane); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [1:0]  pat [10];
    logic [1:0]  g;
    logic [16:0] exp_q [$];
    logic [16:0] e;
`ifdef ALU_ARB_FIXED_PRIO_EN
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
`else
    pat = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
`endif
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd10; bus.req_b0 = 16'd1;
    bus.req_op1 = 12'h002; bus.req_a1 = 16'd20; bus.req_b1 = 16'd5;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) bus.req_valid = 2'b00;
      #1;
      g = bus.req_ready;
      if (i < 10) begin
        checks++; if (g !== pat[i]) begin errors++; $display("FAIL fair_grant: cycle %0d got %b expected %b", i, g, pat[i]); end
        if (g[0]) exp_q.push_back({1'b0, 16'(bus.req_a0 + bus.req_b0)});
        if (g[1]) exp_q.push_back({1'b1, 16'(bus.req_a1 - bus.req_b1)});
      end
      if (bus.res_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL fair_extra: got lane %b data %0d expected no result", bus.res_lane, bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.res_lane, bus.res_data} !== e) begin
            errors++; $display("FAIL fair_result: got lane %b data %0d expected lane %b data %0d", bus.res_lane, bus.res_data, e[16], e[15:0]);
          end
        end
      end
      tick();
      if (i < 10 && g[0]) bus.req_a0 = bus.req_a0 + 16'd1;
      if (i < 10 && g[1]) bus.req_a1 = bus.req_a1 + 16'd1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_missing: %0d results outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_credit();
    do_reset();
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd1; bus.req_b0 = 16'd2;
    bus.req_op1 = 12'h001; bus.req_a1 = 16'd3; bus.req_b1 = 16'd4;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ((bus.req_ready !== 2'b00) != (i < 4)) begin
        errors++; $display("FAIL credit_fill: cycle %0d got %b expected %s", i, bus.req_ready, (i < 4) ? "grant" : "00");
      end
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL credit_no_bypass: got %b expected 00", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL credit_full_valid: got %b expected 1", bus.res_valid); end
    tick();
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL credit_one_grant: got %b expected 01", bus.req_ready); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL credit_refull_a: got %b expected 00", bus.req_ready); end
    tick();
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL credit_refull_b: got %b expected 00", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_full_wrap();
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic        g;
    int          issued;
    int          popped;
    issued = 0;
    popped = 0;
    do_reset();
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd100; bus.req_b0 = 16'd0;
    bus.req_valid = 2'b01;
    for (int i = 0; i < 60 && popped < 12; i++) begin
      if (i == 8) bus.res_ready = 1'b1;
      #1;
      if (i == 7) begin
        checks++; if (bus.res_valid !== 1'b1 || bus.req_ready !== 2'b00) begin
          errors++; $display("FAIL wrap_full: got valid %b ready %b expected 1 00", bus.res_valid, bus.req_ready);
        end
      end
      g = bus.req_ready[0];
      if (g) exp_q.push_back(16'd100 + 16'(issued));
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        checks++;
        popped++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_extra: got %0d expected no result", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_data !== e || bus.res_lane !== 1'b0) begin
            errors++; $display("FAIL wrap_data: got %0d lane %b expected %0d lane 0", bus.res_data, bus.res_lane, e);
          end
        end
      end
      tick();
      if (g) begin
        issued++;
        bus.req_a0 = bus.req_a0 + 16'd1;
        if (issued == 12) bus.req_valid = 2'b00;
      end
    end
    checks++; if (popped != 12) begin errors++; $display("FAIL wrap_count: got %0d results expected 12", popped); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing: %0d outstanding expected 0", exp_q.size()); end
  endtask

  task automatic test_invalid();
    logic found;
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd5; bus.req_b0 = 16'd6;
    bus.req_op1 = 12'h003; bus.req_a1 = 16'd1; bus.req_b1 = 16'd1;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (bus.req_ready[1] !== 1'b0) begin errors++; $display("FAIL inv_lane1_grant: cycle %0d got 1 expected 0", i); end
      checks++; if (bus.op_err !== (i == 1)) begin errors++; $display("FAIL inv_op_err: cycle %0d got %b expected %b", i, bus.op_err, (i == 1)); end
      if (i == 0) begin
        checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL inv_lane0_grant: got %b expected 1", bus.req_ready[0]); end
      end
      if (bus.res_valid === 1'b1) begin
        checks++; if (bus.res_data !== 16'd11 || bus.res_lane !== 1'b0) begin
          errors++; $display("FAIL inv_lane0_result: got %0d lane %b expected 11 lane 0", bus.res_data, bus.res_lane);
        end
      end
      tick();
    end
    bus.req_op1 = 12'h001;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (bus.req_ready[1] === 1'b1) found = 1'b1;
      checks++; if (bus.op_err !== 1'b0) begin errors++; $display("FAIL inv_err_after_fix: got %b expected 0", bus.op_err); end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL inv_unblock: lane 1 grant got none expected one"); end
    bus.req_valid = 2'b00;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_op0 = 12'h001; bus.req_a0 = 16'd1; bus.req_b0 = 16'd1;
    bus.req_valid = 2'b01;
    repeat (6) tick();
    #1;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.res_valid); end
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d got valid %b data %0d expected 0", i, bus.res_valid, bus.res_data); end
      tick();
    end
    bus.res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_reset_start();
    test_immediate();
    test_fairness();
    test_credit();
    test_full_wrap();
    test_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
